axil_req_arbiter: RTL and testbench
===================================

AXIL_REQ_ARBITER -- requirements
Module: axil_req_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8, data width of the shared AXI4-Lite front end.
REQ-002 Parameter ADDR_WIDTH, default 7, address width of the shared front end.
REQ-003 Parameter TIMEOUT_CYCLES, default 64, watchdog limit in ACLK cycles (used only with ARB_TIMEOUT_EN).
REQ-004 ACLK  in  1  single clock; all logic on rising edge.
REQ-005 ARESET  in  1  reset, asynchronous, active-high.
REQ-006 cN_req  in  1  client N (N=0,1) transaction request; level, held until cN_done.
REQ-007 cN_we  in  1  client N direction: 1 = write, 0 = read.
REQ-008 cN_addr  in  ADDR_WIDTH  client N address.
REQ-009 cN_wdata  in  DATA_WIDTH  client N write data.
REQ-010 cN_gnt  out  1  client N owns the front end.
REQ-011 cN_done  out  1  one-cycle completion pulse to client N.
REQ-012 cN_rdata  out  DATA_WIDTH  client N read data, registered.
REQ-013 m_write_request / m_read_request  out  1  level request to the AXI4-Lite master front end.
REQ-014 m_waddr / m_raddr  out  ADDR_WIDTH; m_wdata  out  DATA_WIDTH  latched transaction fields.
REQ-015 m_rdata  in  DATA_WIDTH  read data from the front end, valid on m_rdone.
REQ-016 m_wdone / m_rdone  in  1  one-cycle completion from the front end.
REQ-017 busy  out  1  state != IDLE; txn_count  out  8  completed-transaction count; err  out  1  timeout pulse.

Function
REQ-018 FSM states IDLE, BUSY, DONE; encoding is free.
REQ-019 IDLE: when any cN_req=1, arbitrate, latch the winner's we/addr/wdata, assert its cN_gnt, go to BUSY on the next edge.
REQ-020 Round-robin: pointer rr names the preferred client; if both request, rr wins; if one requests, it wins regardless of rr.
REQ-021 rr becomes the non-winning client at each completion; rr is unchanged in idle cycles.
REQ-022 BUSY: hold m_write_request (we=1) or m_read_request (we=0) high, the other low; m_* address/data fields stable.
REQ-023 BUSY exit: m_wdone for a write, or m_rdone for a read, moves the FSM to DONE; the opposite-type done is ignored.
REQ-024 On the m_rdone capture edge, store m_rdata in the granted client's cN_rdata; the other client's cN_rdata is unchanged.
REQ-025 DONE, one cycle: cN_done=1 for the granted client, m_*_request=0, txn_count+1 (255 wraps to 0), cN_gnt dropped at exit, return to IDLE.
REQ-026 Latency: req seen at edge k -> gnt and m_*_request high from k+1; front-end done at edge j -> cN_done high during cycle j+1.
REQ-027 Requests are sampled only in IDLE; cN_req changes, including deassertion, during BUSY/DONE have no effect on the current transaction.
REQ-028 A client still requesting in IDLE right after its done is re-arbitrated normally; no back-to-back starvation because rr rotates.
REQ-029 At most one cN_gnt and one m_*_request high at any time.

Reset
REQ-030 ARESET=1 immediately forces: state IDLE, rr=0, all cN_gnt/cN_done/m_*_request/err/busy=0, cN_rdata=0, m_* fields=0, txn_count=0, watchdog=0.
REQ-031 Reset during BUSY or DONE aborts the transaction; no cN_done is issued after release.

Configuration
REQ-032 Macro ARB_TIMEOUT_EN defined: watchdog counts BUSY cycles; at TIMEOUT_CYCLES without a matching done, drop m_*_request, enter DONE, pulse cN_done and err together, write cN_rdata=0 for reads, count the transaction, rotate rr.
REQ-033 Macro ARB_TIMEOUT_EN undefined: no watchdog logic; BUSY waits indefinitely; err tied to 0.

Verification
REQ-034 c0 write addr=0x05 data=0xA5, m_wdone three cycles after request -> m_waddr=0x05, m_wdata=0xA5, c0_done one cycle, txn_count=1.
REQ-035 Both clients request in the same cycle after reset -> c0 served first, then c1; a third simultaneous request serves c0 again (rr rotation).
REQ-036 c1 read addr=0x7F, m_rdone with m_rdata=0x3C -> c1_rdata=0x3C, c0_rdata unchanged, m_raddr=0x7F.
REQ-037 Write in BUSY with a spurious m_rdone -> ignored; FSM completes only on m_wdone.
REQ-038 ARESET pulse mid-BUSY -> all outputs 0 immediately, no done after release; with ARB_TIMEOUT_EN and no front-end done -> err and cN_done high together after 64 BUSY cycles.

Source files
------------

// File: rtl/axil_req_arbiter.sv
// Two-client round-robin arbiter in front of a shared AXI4-Lite master front end.
// Optional busy watchdog enabled by defining ARB_TIMEOUT_EN.
module axil_req_arbiter #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 7,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  c0_req,
  input  logic                  c0_we,
  input  logic [ADDR_WIDTH-1:0] c0_addr,
  input  logic [DATA_WIDTH-1:0] c0_wdata,
  output logic                  c0_gnt,
  output logic                  c0_done,
  output logic [DATA_WIDTH-1:0] c0_rdata,
  input  logic                  c1_req,
  input  logic                  c1_we,
  input  logic [ADDR_WIDTH-1:0] c1_addr,
  input  logic [DATA_WIDTH-1:0] c1_wdata,
  output logic                  c1_gnt,
  output logic                  c1_done,
  output logic [DATA_WIDTH-1:0] c1_rdata,
  output logic                  m_write_request,
  output logic                  m_read_request,
  output logic [ADDR_WIDTH-1:0] m_waddr,
  output logic [ADDR_WIDTH-1:0] m_raddr,
  output logic [DATA_WIDTH-1:0] m_wdata,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  input  logic                  m_wdone,
  input  logic                  m_rdone,
  output logic                  busy,
  output logic [7:0]            txn_count,
  output logic                  err,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  rr_q, rr_d;
  logic                  owner_q, owner_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
  logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  win1;
  logic                  fin;

`ifdef ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            to_q, to_d;
`endif

  // c1 wins when it is the only requester or when rr prefers it.
  assign win1 = c1_req & (~c0_req | rr_q);
  assign fin  = we_q ? m_wdone : m_rdone;

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    owner_d  = owner_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    cnt_d    = cnt_q;
`ifdef ARB_TIMEOUT_EN
    wd_d     = wd_q;
    to_d     = to_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (c0_req || c1_req) begin
          owner_d = win1;
          we_d    = win1 ? c1_we    : c0_we;
          addr_d  = win1 ? c1_addr  : c0_addr;
          wdata_d = win1 ? c1_wdata : c0_wdata;
          state_d = S_BUSY;
`ifdef ARB_TIMEOUT_EN
          wd_d    = '0;
`endif
        end
      end
      S_BUSY: begin
        if (fin) begin
          state_d = S_DONE;
          cnt_d   = cnt_q + 8'd1;
          rr_d    = ~owner_q;
          if (!we_q) begin
            if (owner_q) rdata1_d = m_rdata;
            else         rdata0_d = m_rdata;
          end
        end
`ifdef ARB_TIMEOUT_EN
        else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = S_DONE;
          cnt_d   = cnt_q + 8'd1;
          rr_d    = ~owner_q;
          to_d    = 1'b1;
          if (!we_q) begin
            if (owner_q) rdata1_d = '0;
            else         rdata0_d = '0;
          end
        end else begin
          wd_d = wd_q + 1'b1;
        end
`endif
      end
      S_DONE: begin
        state_d = S_IDLE;
`ifdef ARB_TIMEOUT_EN
        to_d    = 1'b0;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q  <= S_IDLE;
      rr_q     <= 1'b0;
      owner_q  <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      cnt_q    <= '0;
`ifdef ARB_TIMEOUT_EN
      wd_q     <= '0;
      to_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      cnt_q    <= cnt_d;
`ifdef ARB_TIMEOUT_EN
      wd_q     <= wd_d;
      to_q     <= to_d;
`endif
    end
  end

  // Grant spans BUSY and DONE; owner_q is only meaningful outside IDLE.
  assign busy            = (state_q != S_IDLE);
  assign c0_gnt          = busy & ~owner_q;
  assign c1_gnt          = busy & owner_q;
  assign c0_done         = (state_q == S_DONE) & ~owner_q;
  assign c1_done         = (state_q == S_DONE) & owner_q;
  assign m_write_request = (state_q == S_BUSY) & we_q;
  assign m_read_request  = (state_q == S_BUSY) & ~we_q;
  assign m_waddr         = addr_q;
  assign m_raddr         = addr_q;
  assign m_wdata         = wdata_q;
  assign c0_rdata        = rdata0_q;
  assign c1_rdata        = rdata1_q;
  assign txn_count       = cnt_q;
  assign dbg_state       = state_q;
`ifdef ARB_TIMEOUT_EN
  assign err             = (state_q == S_DONE) & to_q;
`else
  assign err             = 1'b0;
`endif

endmodule

// File: tb/tb_axil_req_arbiter.sv
// Directed bench for axil_req_arbiter: vector table of complete transactions plus
// hand-written reset, request-deassertion and (optional) watchdog sequences.
module tb_axil_req_arbiter;

  // clock / reset
  logic       ACLK = 1'b0;
  logic       ARESET = 1'b1;
  always #5 ACLK = ~ACLK;

  logic       c0_req, c0_we, c1_req, c1_we;
  logic [6:0] c0_addr, c1_addr;
  logic [7:0] c0_wdata, c1_wdata;
  logic       c0_gnt, c0_done, c1_gnt, c1_done;
  logic [7:0] c0_rdata, c1_rdata;
  logic       m_write_request, m_read_request;
  logic [6:0] m_waddr, m_raddr;
  logic [7:0] m_wdata, m_rdata;
  logic       m_wdone, m_rdone;
  logic       busy, err;
  logic [7:0] txn_count;
  logic [1:0] dbg_state;

  axil_req_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(7), .TIMEOUT_CYCLES(64)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .c0_req(c0_req), .c0_we(c0_we), .c0_addr(c0_addr), .c0_wdata(c0_wdata),
    .c0_gnt(c0_gnt), .c0_done(c0_done), .c0_rdata(c0_rdata),
    .c1_req(c1_req), .c1_we(c1_we), .c1_addr(c1_addr), .c1_wdata(c1_wdata),
    .c1_gnt(c1_gnt), .c1_done(c1_done), .c1_rdata(c1_rdata),
    .m_write_request(m_write_request), .m_read_request(m_read_request),
    .m_waddr(m_waddr), .m_raddr(m_raddr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_wdone(m_wdone), .m_rdone(m_rdone),
    .busy(busy), .txn_count(txn_count), .err(err), .dbg_state(dbg_state)
  );

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // At most one grant and one front-end request at any sampled point.
  always @(negedge ACLK) begin
    if (!ARESET) begin
      check("one_gnt", {31'd0, c0_gnt & c1_gnt}, 32'd0);
      check("one_mreq", {31'd0, m_write_request & m_read_request}, 32'd0);
    end
  end

  typedef struct {
    logic       c0_req; logic c0_we; logic [6:0] c0_addr; logic [7:0] c0_wdata;
    logic       c1_req; logic c1_we; logic [6:0] c1_addr; logic [7:0] c1_wdata;
    int         delay;  logic spur;  logic [7:0] rdata;
    logic       exp_win; logic [6:0] exp_addr; logic [7:0] exp_wdata; logic exp_we;
    logic [7:0] exp_rd0; logic [7:0] exp_rd1; logic [7:0] exp_cnt;
  } vec_t;

  vec_t vecs[8];

  task automatic idle_inputs();
    c0_req = 0; c0_we = 0; c0_addr = '0; c0_wdata = '0;
    c1_req = 0; c1_we = 0; c1_addr = '0; c1_wdata = '0;
    m_rdata = '0; m_wdone = 0; m_rdone = 0;
  endtask

  // driver: one full transaction described by a table row
  task automatic run_vec(input int idx, input vec_t v);
    string p;
    p = $sformatf("v%0d_", idx);
    exp_q.push_back(v.exp_cnt);
    @(negedge ACLK);
    c0_req = v.c0_req; c0_we = v.c0_we; c0_addr = v.c0_addr; c0_wdata = v.c0_wdata;
    c1_req = v.c1_req; c1_we = v.c1_we; c1_addr = v.c1_addr; c1_wdata = v.c1_wdata;
    @(negedge ACLK);
    check({p, "gnt0"}, {31'd0, c0_gnt}, {31'd0, ~v.exp_win});
    check({p, "gnt1"}, {31'd0, c1_gnt}, {31'd0, v.exp_win});
    check({p, "wreq"}, {31'd0, m_write_request}, {31'd0, v.exp_we});
    check({p, "rreq"}, {31'd0, m_read_request}, {31'd0, ~v.exp_we});
    check({p, "addr"}, {25'd0, v.exp_we ? m_waddr : m_raddr}, {25'd0, v.exp_addr});
    if (v.exp_we) check({p, "wdata"}, {24'd0, m_wdata}, {24'd0, v.exp_wdata});
    repeat (v.delay - 1) @(negedge ACLK);
    if (v.spur) begin
      m_rdata = 8'h99;
      if (v.exp_we) m_rdone = 1; else m_wdone = 1;
      @(negedge ACLK);
      m_rdone = 0; m_wdone = 0;
      check({p, "spur_state"}, {30'd0, dbg_state}, 32'd1);
      check({p, "spur_done"}, {30'd0, c1_done, c0_done}, 32'd0);
    end
    m_rdata = v.rdata;
    if (v.exp_we) m_wdone = 1; else m_rdone = 1;
    @(negedge ACLK);
    m_wdone = 0; m_rdone = 0; m_rdata = 8'h00;
    c0_req = 0; c1_req = 0;
    check({p, "done"}, {30'd0, c1_done, c0_done}, v.exp_win ? 32'd2 : 32'd1);
    check({p, "done_state"}, {30'd0, dbg_state}, 32'd2);
    check({p, "done_mreq"}, {30'd0, m_write_request, m_read_request}, 32'd0);
    check({p, "err"}, {31'd0, err}, 32'd0);
    @(negedge ACLK);
    check({p, "idle"}, {28'd0, busy, c0_gnt, c1_gnt, c0_done | c1_done}, 32'd0);
    check({p, "count"}, {24'd0, txn_count}, {24'd0, exp_q.pop_front()});
    check({p, "rd0"}, {24'd0, c0_rdata}, {24'd0, v.exp_rd0});
    check({p, "rd1"}, {24'd0, c1_rdata}, {24'd0, v.exp_rd1});
  endtask

  initial begin
    idle_inputs();
    //            c0 req/we/addr/wdata     c1 req/we/addr/wdata    dly spur rdata  win addr  wdata we  rd0    rd1    cnt
    vecs[0] = '{1, 1, 7'h05, 8'hA5, 1, 0, 7'h33, 8'h00, 3, 0, 8'h00, 0, 7'h05, 8'hA5, 1, 8'h00, 8'h00, 8'd1};
    vecs[1] = '{1, 0, 7'h11, 8'h00, 1, 1, 7'h22, 8'hBB, 1, 0, 8'h00, 1, 7'h22, 8'hBB, 1, 8'h00, 8'h00, 8'd2};
    vecs[2] = '{1, 0, 7'h44, 8'h00, 1, 1, 7'h55, 8'h66, 2, 0, 8'h5A, 0, 7'h44, 8'h00, 0, 8'h5A, 8'h00, 8'd3};
    vecs[3] = '{0, 0, 7'h00, 8'h00, 1, 0, 7'h7F, 8'h00, 2, 0, 8'h3C, 1, 7'h7F, 8'h00, 0, 8'h5A, 8'h3C, 8'd4};
    vecs[4] = '{0, 0, 7'h00, 8'h00, 1, 1, 7'h01, 8'hFF, 2, 1, 8'h99, 1, 7'h01, 8'hFF, 1, 8'h5A, 8'h3C, 8'd5};
    vecs[5] = '{1, 0, 7'h00, 8'h00, 0, 0, 7'h00, 8'h00, 1, 1, 8'h81, 0, 7'h00, 8'h00, 0, 8'h81, 8'h3C, 8'd6};
    vecs[6] = '{1, 1, 7'h7F, 8'h00, 0, 0, 7'h00, 8'h00, 4, 0, 8'h00, 0, 7'h7F, 8'h00, 1, 8'h81, 8'h3C, 8'd7};
    vecs[7] = '{1, 1, 7'h0A, 8'h0B, 1, 0, 7'h6C, 8'h00, 1, 0, 8'hE7, 1, 7'h6C, 8'h00, 0, 8'h81, 8'hE7, 8'd8};

    #1;
    check("rst_outs", {24'd0, busy, err, c0_gnt, c1_gnt, c0_done, c1_done,
                       m_write_request, m_read_request}, 32'd0);
    check("rst_count", {24'd0, txn_count}, 32'd0);
    check("rst_fields", {m_waddr, m_wdata, c0_rdata, c1_rdata}, 32'd0);
    repeat (2) @(negedge ACLK);
    ARESET = 0;

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Request changes during BUSY must not disturb the transaction (rr=0 now).
    @(negedge ACLK);
    c0_req = 1; c0_we = 1; c0_addr = 7'h12; c0_wdata = 8'h34;
    @(negedge ACLK);
    c0_req = 0; c0_addr = 7'h00; c0_wdata = 8'h00;
    c1_req = 1; c1_we = 1; c1_addr = 7'h2B; c1_wdata = 8'h2C;
    @(negedge ACLK);
    check("hold_gnt0", {30'd0, c1_gnt, c0_gnt}, 32'd1);
    check("hold_fields", {17'd0, m_waddr, m_wdata}, {17'd0, 7'h12, 8'h34});
    m_wdone = 1;
    @(negedge ACLK);
    m_wdone = 0;
    check("hold_done", {30'd0, c1_done, c0_done}, 32'd1);
    check("hold_count", {24'd0, txn_count}, 32'd9);
    @(negedge ACLK);
    check("rearb_idle", {31'd0, busy}, 32'd0);
    @(negedge ACLK);
    check("rearb_gnt1", {30'd0, c1_gnt, c0_gnt}, 32'd2);
    check("rearb_fields", {17'd0, m_waddr, m_wdata}, {17'd0, 7'h2B, 8'h2C});

    // Asynchronous reset in the middle of BUSY.
    #2 ARESET = 1;
    #1;
    check("midrst_outs", {24'd0, busy, err, c0_gnt, c1_gnt, c0_done, c1_done,
                          m_write_request, m_read_request}, 32'd0);
    check("midrst_count", {24'd0, txn_count}, 32'd0);
    check("midrst_fields", {m_waddr, m_wdata, c0_rdata, c1_rdata}, 32'd0);
    @(negedge ACLK);
    ARESET = 0; c1_req = 0; m_wdone = 1;
    @(negedge ACLK);
    m_wdone = 0;
    for (int i = 0; i < 3; i++) begin
      check("midrst_nodone", {29'd0, busy, c1_done, c0_done}, 32'd0);
      @(negedge ACLK);
    end

    // rr returned to c0 by the reset.
    c0_req = 1; c0_we = 0; c0_addr = 7'h03;
    c1_req = 1; c1_we = 0; c1_addr = 7'h04;
    @(negedge ACLK);
    check("rstrr_gnt0", {30'd0, c1_gnt, c0_gnt}, 32'd1);
    check("rstrr_raddr", {25'd0, m_raddr}, 32'h03);
    c1_req = 0;

`ifdef ARB_TIMEOUT_EN
    // No front-end done: watchdog closes the read after 64 BUSY cycles.
    repeat (63) @(negedge ACLK);
    check("wd_still_busy", {30'd0, dbg_state}, 32'd1);
    check("wd_no_err", {31'd0, err}, 32'd0);
    @(negedge ACLK);
    c0_req = 0;
    check("wd_done_err", {29'd0, err, c1_done, c0_done}, 32'd5);
    check("wd_mreq_low", {30'd0, m_write_request, m_read_request}, 32'd0);
    @(negedge ACLK);
    check("wd_count", {24'd0, txn_count}, 32'd1);
    check("wd_rdata", {24'd0, c0_rdata}, 32'd0);
    check("wd_err_pulse", {31'd0, err}, 32'd0);
`else
    repeat (80) @(negedge ACLK);
    check("nowd_still_busy", {30'd0, dbg_state}, 32'd1);
    check("nowd_no_err", {29'd0, err, c1_done, c0_done}, 32'd0);
    c0_req = 0;
    m_rdone = 1; m_rdata = 8'h6E;
    @(negedge ACLK);
    m_rdone = 0;
    check("nowd_done", {30'd0, c1_done, c0_done}, 32'd1);
    @(negedge ACLK);
    check("nowd_rdata", {24'd0, c0_rdata}, 32'h6E);
    check("nowd_count", {24'd0, txn_count}, 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
